fp_add_sub: RTL and testbench
=============================

Name: fp_add_sub

Overview:
- Multi-cycle IEEE-754 adder/subtractor.
- It is the responder on the adder interface that the FP divider drives. It takes A, B, Op and a one-cycle Load, then returns Result with a one-cycle Valid pulse.
- Shared by the divider and by top-level add/sub instructions. Single or double precision is chosen by parameter.

Parameters:
PRECISION, 32, operand width; 32 = single (8-bit exp, 23-bit frac), 64 = double (11-bit exp, 52-bit frac)

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  synchronous active-low reset
A  input  PRECISION  first operand
B  input  PRECISION  second operand
Op  input  1  0 = A+B, 1 = A-B
Load  input  1  start request; sampled only when Enable=1
Enable  input  1  clock enable; when 0 all state holds
Result  output  PRECISION  result, held until next Load or reset
Valid  output  1  one-cycle pulse, Result is valid

Behaviour:
- One clock (Clk). Reset is synchronous and active-low (Rst_n). Rst_n=0 wins over Load/Enable.
- Reset values: Result=0, Valid=0, FSM=IDLE, all internal registers 0.
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND.
- Load&Enable in any state latches A and B. B's sign is XORed with Op before latching. Valid<=0 on the same edge. A Load while busy aborts the current op silently; there is no Valid for the aborted op.
- Special cases, decided on the Load edge. Result is registered, then Valid pulses on the next edge (latency 1):
  - either input NaN, or Inf + (−Inf) after the Op sign flip → canonical NaN: sign 0, exp all-1s, frac all-1s (32-bit: 7FFFFFFF).
  - exactly one input Inf → that Inf, with its effective sign.
  - exponent field 0 (zero or denormal) → treated as signed zero. Result = other operand with its effective sign. Both zero → +0, except (−0)+(−0) = −0.
- Normal path, fixed latency. With Load sampled at edge T0, Valid=1 from edge T0+4 to edge T0+5:
  - ALIGN: swap so that |X| ≥ |Y| (compare exp, then frac). Right-shift Y's significand (hidden bit restored) by the exponent difference, capped at frac+3 bits. Keep guard, round and sticky bits.
  - ADD: add, or subtract if the effective signs differ. Result sign = sign of X.
  - NORM: on carry-out, shift right 1 and increment exp. Otherwise, left-shift by the leading-zero count and decrement exp. An all-zero sum → +0; skip rounding, Valid still at T0+4.
  - ROUND: round-to-nearest-even from guard/round/sticky. A mantissa overflow after rounding renormalises and increments exp.
  - Result exp ≥ all-1s → signed Inf (overflow). Exp ≤ 0 → signed zero (flush-to-zero, no denormal output).
- Valid is exactly one cycle. It is never high on the cycle a Load is sampled, so a requester sampling Valid after Load never sees a stale result.
- Enable=0 mid-operation: FSM, Result and Valid freeze. A pending Valid pulse is held until Enable returns, then lasts one enabled cycle.
- Reset mid-operation: return to IDLE, no Valid.
- The behaviour for PRECISION=64 is identical with widened fields.

Test Plan:
- A=3F800000, B=40000000, Op=0 → Result=40400000, Valid pulse exactly 4 cycles after the Load edge; Result is held afterwards.
- A=40400000, B=3F800000, Op=1 → 40000000. Also A=3F800001, B=3F800000, Op=1 (massive cancellation) → 34000000.
- Rounding: 3F800000+33800000 (tie) → 3F800000; 3F800001+33800000 → 3F800002. Also 3F800000+3F800000 with Op=1 → +0 (00000000).
- Specials, each with Valid 1 cycle after Load:
  - 7F800000 − 7F800000 → 7FFFFFFF.
  - 7FC00000 + 3F800000 → 7FFFFFFF.
  - FF800000 + 3F800000 → FF800000.
  - 80000000 + 80000000 → 80000000.
- Overflow/underflow:
  - 7F7FFFFF+7F7FFFFF → 7F800000.
  - 00800001 − 00800000 → 00000000.
  - 00400000 (denormal) + 3F800000 → 3F800000.
- Control: a second Load 2 cycles into an op → a single Valid, for the second op, at 4 cycles after its Load. Enable=0 for 3 cycles mid-op → Valid delayed by 3 cycles. Rst_n=0 mid-op → Valid=0, Result=0, idle; the next Load works normally.

Source files
------------

// File: rtl/fp_add_sub.sv
// Multi-cycle IEEE-754 adder/subtractor with round-to-nearest-even.
// Special operands resolve on the Load edge; normal operands take four stages.
module fp_add_sub #(
   parameter int PRECISION = 32
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic [PRECISION-1:0] A,
   input  logic [PRECISION-1:0] B,
   input  logic                 Op,
   input  logic                 Load,
   input  logic                 Enable,
   output logic [PRECISION-1:0] Result,
   output logic                 Valid
);

   localparam int EW = (PRECISION == 64) ? 11 : 8;
   localparam int FW = PRECISION - EW - 1;
   localparam int SW = FW + 4;
   localparam int XW = EW + 2;
   localparam int LW = $clog2(SW + 1);
   localparam logic [EW-1:0] SHMAX = EW'(SW - 1);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;
   state_t state, nextState;

   logic [PRECISION-1:0] aReg, bReg, bEff;
   logic                 specFlag, zeroFlag, xSign, subOp;
   logic [XW-1:0]        expReg;
   logic [SW-1:0]        xSig, ySig, normSig;
   logic [SW:0]          sumReg;

   assign bEff = {B[PRECISION-1] ^ Op, B[PRECISION-2:0]};

   // Special operand detection on the raw inputs
   logic [EW-1:0] aExpIn, bExpIn;
   logic          aNan, bNan, aInf, bInf, aZero, bZero, specHit;
   logic [PRECISION-1:0] specVal;

   assign aExpIn = A[PRECISION-2:FW];
   assign bExpIn = B[PRECISION-2:FW];
   assign aNan   = (aExpIn == '1) && (A[FW-1:0] != '0);
   assign bNan   = (bExpIn == '1) && (B[FW-1:0] != '0);
   assign aInf   = (aExpIn == '1) && (A[FW-1:0] == '0);
   assign bInf   = (bExpIn == '1) && (B[FW-1:0] == '0);
   assign aZero  = (aExpIn == '0);
   assign bZero  = (bExpIn == '0);

   always_comb begin
      specHit = 1'b1;
      specVal = '0;
      if (aNan || bNan || (aInf && bInf && (A[PRECISION-1] != bEff[PRECISION-1])))
         specVal = {1'b0, {(PRECISION-1){1'b1}}};
      else if (aInf)
         specVal = A;
      else if (bInf)
         specVal = bEff;
      else if (aZero && bZero)
         specVal = {A[PRECISION-1] & bEff[PRECISION-1], {(PRECISION-1){1'b0}}};
      else if (aZero)
         specVal = bEff;
      else if (bZero)
         specVal = A;
      else
         specHit = 1'b0;
   end

   // Alignment: larger magnitude becomes X, Y shifts right with sticky
   logic                 swap, lost;
   logic [PRECISION-1:0] xOp, yOp;
   logic [EW-1:0]        diff, shAmt;
   logic [SW-1:0]        xExt, yExt, yShift, ySh;

   always_comb begin
      swap   = bReg[PRECISION-2:0] > aReg[PRECISION-2:0];
      xOp    = swap ? bReg : aReg;
      yOp    = swap ? aReg : bReg;
      diff   = xOp[PRECISION-2:FW] - yOp[PRECISION-2:FW];
      shAmt  = (diff > SHMAX) ? SHMAX : diff;
      xExt   = {1'b1, xOp[FW-1:0], 3'b000};
      yExt   = {1'b1, yOp[FW-1:0], 3'b000};
      yShift = yExt >> shAmt;
      lost   = |(yExt & ~({SW{1'b1}} << shAmt));
      ySh    = {yShift[SW-1:1], yShift[0] | lost};
   end

   logic [LW-1:0] lzc;
   logic          found;
   logic [SW-1:0] normNext;
   logic [XW-1:0] expNext;

   always_comb begin
      lzc   = '0;
      found = 1'b0;
      for (int i = SW - 1; i >= 0; i--) begin
         if (!found && sumReg[i]) begin
            found = 1'b1;
            lzc   = LW'(SW - 1 - i);
         end
      end
      if (sumReg[SW]) begin
         normNext = {sumReg[SW:2], sumReg[1] | sumReg[0]};
         expNext  = expReg + XW'(1);
      end else begin
         normNext = sumReg[SW-1:0] << lzc;
         expNext  = expReg - {{(XW-LW){1'b0}}, lzc};
      end
   end

   logic [FW:0]          mant;
   logic                 roundUp;
   logic [FW+1:0]        mantR;
   logic [XW-1:0]        expR;
   logic [FW-1:0]        fracOut;
   logic [PRECISION-1:0] roundRes;

   always_comb begin
      mant    = normSig[SW-1:3];
      roundUp = normSig[2] & (normSig[1] | normSig[0] | mant[0]);
      mantR   = {1'b0, mant} + {{(FW+1){1'b0}}, roundUp};
      if (mantR[FW+1]) begin
         fracOut = mantR[FW:1];
         expR    = expReg + XW'(1);
      end else begin
         fracOut = mantR[FW-1:0];
         expR    = expReg;
      end
      if (!expR[XW-1] && expR >= {2'b00, {EW{1'b1}}})
         roundRes = {xSign, {EW{1'b1}}, {FW{1'b0}}};
      else if (expR[XW-1] || expR == '0)
         roundRes = {xSign, {(PRECISION-1){1'b0}}};
      else
         roundRes = {xSign, expR[EW-1:0], fracOut};
   end

   always_comb begin
      nextState = state;
      if (Load)
         nextState = specHit ? ROUND : ALIGN;
      else begin
         unique case (state)
            ALIGN:   nextState = ADD;
            ADD:     nextState = NORM;
            NORM:    nextState = ROUND;
            ROUND:   nextState = IDLE;
            default: nextState = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n)
         state <= IDLE;
      else if (Enable)
         state <= nextState;
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         aReg     <= '0;
         bReg     <= '0;
         specFlag <= 1'b0;
         zeroFlag <= 1'b0;
         xSign    <= 1'b0;
         subOp    <= 1'b0;
         expReg   <= '0;
         xSig     <= '0;
         ySig     <= '0;
         sumReg   <= '0;
         normSig  <= '0;
         Result   <= '0;
         Valid    <= 1'b0;
      end else if (Enable) begin
         Valid <= 1'b0;
         if (Load) begin
            aReg     <= A;
            bReg     <= bEff;
            specFlag <= specHit;
            zeroFlag <= 1'b0;
            if (specHit)
               Result <= specVal;
         end else begin
            unique case (state)
               ALIGN: begin
                  xSign  <= xOp[PRECISION-1];
                  subOp  <= aReg[PRECISION-1] ^ bReg[PRECISION-1];
                  expReg <= {2'b00, xOp[PRECISION-2:FW]};
                  xSig   <= xExt;
                  ySig   <= ySh;
               end
               ADD:
                  sumReg <= subOp ? {1'b0, xSig} - {1'b0, ySig}
                                  : {1'b0, xSig} + {1'b0, ySig};
               NORM: begin
                  normSig  <= normNext;
                  expReg   <= expNext;
                  zeroFlag <= (sumReg == '0);
               end
               ROUND: begin
                  Valid <= 1'b1;
                  if (!specFlag)
                     Result <= zeroFlag ? '0 : roundRes;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fp_add_sub.sv
// Directed-vector bench for fp_add_sub (single precision).
// Each scenario task drives its own stimulus and checks inline.
module tb_fp_add_sub;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Op = 1'b0;
   logic        Load = 1'b0;
   logic        Enable = 1'b1;
   logic [31:0] Result;
   logic        Valid;

   int testsRun = 0;
   int testsFailed = 0;

   fp_add_sub #(.PRECISION(32)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .A(A), .B(B), .Op(Op),
      .Load(Load), .Enable(Enable), .Result(Result), .Valid(Valid)
   );

   always #5 Clk = ~Clk;

   // Issue one Load and return result plus edges until Valid (-1 = none)
   task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                        input logic op, output logic [31:0] res,
                        output int lat);
      @(negedge Clk);
      A = a; B = b; Op = op; Load = 1'b1;
      @(posedge Clk);
      #1 Load = 1'b0;
      lat = -1;
      if (Valid) lat = 0;
      for (int c = 1; c <= 12 && lat < 0; c++) begin
         @(posedge Clk);
         #1;
         if (Valid) lat = c;
      end
      res = Result;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      testsRun++;
      if (Result !== 32'h0) begin
         testsFailed++;
         $display("FAIL reset_result got %h want %h", Result, 32'h0);
      end
      testsRun++;
      if (Valid !== 1'b0) begin
         testsFailed++;
         $display("FAIL reset_valid got %b want 0", Valid);
      end
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic test_add_sub();
      logic [31:0] r;
      int lat;
      runOp(32'h3F800000, 32'h40000000, 1'b0, r, lat);
      testsRun++;
      if (r !== 32'h40400000) begin
         testsFailed++;
         $display("FAIL add_1p2 got %h want %h", r, 32'h40400000);
      end
      testsRun++;
      if (lat !== 4) begin
         testsFailed++;
         $display("FAIL add_latency got %0d want 4", lat);
      end
      @(posedge Clk);
      #1;
      testsRun++;
      if (Valid !== 1'b0) begin
         testsFailed++;
         $display("FAIL valid_width got %b want 0", Valid);
      end
      repeat (3) @(posedge Clk);
      #1;
      testsRun++;
      if (Result !== 32'h40400000) begin
         testsFailed++;
         $display("FAIL result_hold got %h want %h", Result, 32'h40400000);
      end
      runOp(32'h40400000, 32'h3F800000, 1'b1, r, lat);
      testsRun++;
      if (r !== 32'h40000000 || lat !== 4) begin
         testsFailed++;
         $display("FAIL sub_3m1 got %h lat %0d want %h lat 4", r, lat, 32'h40000000);
      end
      runOp(32'h3F800001, 32'h3F800000, 1'b1, r, lat);
      testsRun++;
      if (r !== 32'h34000000 || lat !== 4) begin
         testsFailed++;
         $display("FAIL cancel got %h lat %0d want %h lat 4", r, lat, 32'h34000000);
      end
   endtask

   task automatic test_round();
      logic [31:0] va [3] = '{32'h3F800000, 32'h3F800001, 32'h3F800000};
      logic [31:0] vb [3] = '{32'h33800000, 32'h33800000, 32'h3F800000};
      logic        vo [3] = '{1'b0, 1'b0, 1'b1};
      logic [31:0] ve [3] = '{32'h3F800000, 32'h3F800002, 32'h00000000};
      logic [31:0] r;
      int lat;
      for (int i = 0; i < 3; i++) begin
         runOp(va[i], vb[i], vo[i], r, lat);
         testsRun++;
         if (r !== ve[i] || lat !== 4) begin
            testsFailed++;
            $display("FAIL round_%0d got %h lat %0d want %h lat 4", i, r, lat, ve[i]);
         end
      end
   endtask

   task automatic test_specials();
      logic [31:0] va [4] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h80000000};
      logic [31:0] vb [4] = '{32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h80000000};
      logic        vo [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] ve [4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFF800000, 32'h80000000};
      logic [31:0] r;
      int lat;
      for (int i = 0; i < 4; i++) begin
         runOp(va[i], vb[i], vo[i], r, lat);
         testsRun++;
         if (r !== ve[i] || lat !== 1) begin
            testsFailed++;
            $display("FAIL special_%0d got %h lat %0d want %h lat 1", i, r, lat, ve[i]);
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] va [3] = '{32'h7F7FFFFF, 32'h00800001, 32'h00400000};
      logic [31:0] vb [3] = '{32'h7F7FFFFF, 32'h00800000, 32'h3F800000};
      logic        vo [3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] ve [3] = '{32'h7F800000, 32'h00000000, 32'h3F800000};
      int          vl [3] = '{4, 4, 1};
      logic [31:0] r;
      int lat;
      for (int i = 0; i < 3; i++) begin
         runOp(va[i], vb[i], vo[i], r, lat);
         testsRun++;
         if (r !== ve[i] || lat !== vl[i]) begin
            testsFailed++;
            $display("FAIL ovf_%0d got %h lat %0d want %h lat %0d", i, r, lat, ve[i], vl[i]);
         end
      end
   endtask

   task automatic test_abort();
      int pulses = 0;
      int first = -1;
      @(negedge Clk);
      A = 32'h3F800000; B = 32'h40000000; Op = 1'b0; Load = 1'b1;
      @(posedge Clk);
      #1 Load = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      A = 32'h40400000; B = 32'h3F800000; Op = 1'b1; Load = 1'b1;
      @(posedge Clk);
      #1 Load = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge Clk);
         #1;
         if (Valid) begin
            pulses++;
            if (first < 0) first = c;
         end
      end
      testsRun++;
      if (pulses !== 1) begin
         testsFailed++;
         $display("FAIL abort_pulses got %0d want 1", pulses);
      end
      testsRun++;
      if (first !== 4) begin
         testsFailed++;
         $display("FAIL abort_latency got %0d want 4", first);
      end
      testsRun++;
      if (Result !== 32'h40000000) begin
         testsFailed++;
         $display("FAIL abort_result got %h want %h", Result, 32'h40000000);
      end
   endtask

   task automatic test_enable();
      int pulses = 0;
      int first = -1;
      @(negedge Clk);
      A = 32'h3F800000; B = 32'h40000000; Op = 1'b0; Load = 1'b1;
      @(posedge Clk);
      #1 Load = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge Clk);
         #1;
         if (Valid) begin
            pulses++;
            if (first < 0) first = c;
         end
         if (c == 1) Enable = 1'b0;
         if (c == 4) Enable = 1'b1;
      end
      testsRun++;
      if (first !== 7 || pulses !== 1) begin
         testsFailed++;
         $display("FAIL enable_stall lat %0d pulses %0d want lat 7 pulses 1", first, pulses);
      end
      testsRun++;
      if (Result !== 32'h40400000) begin
         testsFailed++;
         $display("FAIL enable_result got %h want %h", Result, 32'h40400000);
      end
   endtask

   task automatic test_reset_midop();
      int pulses = 0;
      logic [31:0] r;
      int lat;
      @(negedge Clk);
      A = 32'h3F800000; B = 32'h40000000; Op = 1'b0; Load = 1'b1;
      @(posedge Clk);
      #1 Load = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      Rst_n = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge Clk);
         #1;
         if (Valid) pulses++;
      end
      testsRun++;
      if (pulses !== 0 || Result !== 32'h0) begin
         testsFailed++;
         $display("FAIL rst_midop pulses %0d result %h want 0 and %h", pulses, Result, 32'h0);
      end
      runOp(32'h3F800000, 32'h40000000, 1'b0, r, lat);
      testsRun++;
      if (r !== 32'h40400000 || lat !== 4) begin
         testsFailed++;
         $display("FAIL rst_recover got %h lat %0d want %h lat 4", r, lat, 32'h40400000);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_round();
      test_specials();
      test_overflow();
      test_abort();
      test_enable();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
